// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Direction codes and scheduler state shared by the car and floorLight.
// Revision : 1.0
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_DOWN = 2'b01,
        DIR_UP   = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10,
        DOOR_OPEN = 2'b11
    } state_t;

    function automatic dir_t dir_of_state(input state_t s);
        case (s)
            MOVE_UP:   return DIR_UP;
            MOVE_DOWN: return DIR_DOWN;
            default:   return DIR_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_timer.sv
`default_nettype none
// ============================================================================
// Module   : elevator_timer
// Purpose  : Loadable down-counter; done while the count sits at zero.
// Revision : 1.0
// ============================================================================
module elevator_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Purpose  : SCAN car controller with request latch, travel and door timers.
// Revision : 1.0
// ============================================================================
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FLOORS-1:0]         req,
    output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
    output logic [NUM_FLOORS-1:0]         floor_onehot,
    output logic [1:0]                    direction,
    output logic                          door_open,
    output logic [NUM_FLOORS-1:0]         pending,
    output logic                          above,
    output logic                          below
);

    localparam int FLOOR_W  = $clog2(NUM_FLOORS);
    localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);

    localparam logic [TRAVEL_W-1:0] c_TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]   c_DOOR_LOAD   = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]  c_TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    state_t                 state_q, state_d;
    dir_t                   last_dir_q, last_dir_d;
    logic [FLOOR_W-1:0]     cur_floor_q, cur_floor_d;
    logic [NUM_FLOORS-1:0]  pending_q, pending_d;

    logic [NUM_FLOORS-1:0]  w_eff;
    logic [NUM_FLOORS-1:0]  w_above_mask;
    logic [NUM_FLOORS-1:0]  w_below_mask;
    logic [FLOOR_W-1:0]     w_step_floor;
    logic                   w_eff_above;
    logic                   w_eff_below;
    logic                   w_ahead;
    logic                   w_behind;
    logic                   w_scan_go;
    logic                   w_travel_load;
    logic                   w_travel_done;
    logic                   w_door_load;
    logic                   w_door_done;

    always_comb begin
        w_above_mask = '0;
        w_below_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_above_mask[i] = (FLOOR_W'(i) > cur_floor_q);
            w_below_mask[i] = (FLOOR_W'(i) < cur_floor_q);
        end
    end

    // Fresh requests count in the same cycle they arrive.
    assign w_eff        = pending_q | req;
    assign w_eff_above  = |(w_eff & w_above_mask);
    assign w_eff_below  = |(w_eff & w_below_mask);
    assign w_ahead      = (last_dir_q == DIR_UP) ? w_eff_above : w_eff_below;
    assign w_behind     = (last_dir_q == DIR_UP) ? w_eff_below : w_eff_above;
    assign w_step_floor = (state_q == MOVE_DOWN) ? (cur_floor_q - 1'b1) : (cur_floor_q + 1'b1);

    always_comb begin
        state_d       = state_q;
        cur_floor_d   = cur_floor_q;
        last_dir_d    = last_dir_q;
        w_travel_load = 1'b0;
        w_door_load   = 1'b0;
        w_scan_go     = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_eff[cur_floor_q]) begin
                    state_d     = DOOR_OPEN;
                    w_door_load = 1'b1;
                end else begin
                    w_scan_go = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (w_travel_done) begin
                    cur_floor_d = w_step_floor;
                    if (w_eff[w_step_floor]) begin
                        state_d     = DOOR_OPEN;
                        w_door_load = 1'b1;
                    end else begin
                        w_travel_load = 1'b1;
                    end
                end
            end
            DOOR_OPEN: begin
                // A re-press of this floor holds the door rather than latching.
                if (req[cur_floor_q]) begin
                    w_door_load = 1'b1;
                end else if (w_door_done) begin
                    w_scan_go = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_scan_go) begin
            if (w_ahead) begin
                state_d       = (last_dir_q == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                w_travel_load = 1'b1;
            end else if (w_behind) begin
                state_d       = (last_dir_q == DIR_UP) ? MOVE_DOWN : MOVE_UP;
                last_dir_d    = (last_dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                w_travel_load = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        pending_d = pending_q | req;
        if (state_d == DOOR_OPEN) begin
            pending_d[cur_floor_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_dir_q  <= DIR_UP;
            cur_floor_q <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_dir_q  <= last_dir_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
        end
    end

    elevator_timer #(
        .WIDTH (TRAVEL_W)
    ) u_travel_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_travel_load),
        .load_val (c_TRAVEL_LOAD),
        .en       ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)),
        .done     (w_travel_done)
    );

    elevator_timer #(
        .WIDTH (DOOR_W)
    ) u_door_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_door_load),
        .load_val (c_DOOR_LOAD),
        .en       (state_q == DOOR_OPEN),
        .done     (w_door_done)
    );

    a_floor_range: assert property (@(posedge clk) disable iff (!reset) cur_floor_q <= c_TOP_FLOOR);

    assign cur_floor    = cur_floor_q;
    assign floor_onehot = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << cur_floor_q;
    assign direction    = dir_of_state(state_q);
    assign door_open    = (state_q == DOOR_OPEN);
    assign pending      = pending_q;
    assign above        = |(pending_q & w_above_mask);
    assign below        = |(pending_q & w_below_mask);

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scheduler
// Purpose  : Scoreboarded directed bench; each expected door stop is queued.
// Revision : 1.0
// ============================================================================
module tb_elevator_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [1:0] cur_floor;
    logic [3:0] floor_onehot;
    logic [1:0] direction;
    logic       door_open;
    logic [3:0] pending;
    logic       above;
    logic       below;

    elevator_scheduler #(
        .NUM_FLOORS    (4),
        .TRAVEL_CYCLES (8),
        .DOOR_CYCLES   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .cur_floor    (cur_floor),
        .floor_onehot (floor_onehot),
        .direction    (direction),
        .door_open    (door_open),
        .pending      (pending),
        .above        (above),
        .below        (below)
    );

    typedef struct {
        int floor;
        int cycle;
        int len;
    } stop_t;

    stop_t exp_q[$];
    stop_t cur_exp;
    int    cyc       = 0;
    int    n_cmp     = 0;
    int    n_err     = 0;
    int    door_len  = 0;
    bit    door_prev = 0;
    bit    in_door   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one scoreboard entry per door opening.
    always @(negedge clk) begin
        if (!reset) begin
            door_prev = 1'b0;
            in_door   = 1'b0;
        end else begin
            if (door_open && !door_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_stop: got floor %0d at cycle %0d, required no stop", cur_floor, cyc);
                    in_door = 1'b0;
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("stop_floor", int'(cur_floor), cur_exp.floor);
                    check("stop_cycle", cyc, cur_exp.cycle);
                    in_door  = 1'b1;
                    door_len = 0;
                end
            end
            if (door_open) door_len++;
            if (!door_open && door_prev && in_door) begin
                check("door_len", door_len, cur_exp.len);
                in_door = 1'b0;
            end
            door_prev = door_open;
        end
    end

    task automatic push_stop(input int f, input int c, input int l);
        stop_t s;
        s.floor = f;
        s.cycle = c;
        s.len   = l;
        exp_q.push_back(s);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] m, output int t);
        req = m;
        t   = cyc;
        @(posedge clk);
        #1;
        req = 4'b0000;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || door_open || in_door || direction != 2'b00) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL idle_timeout: got %0d stops outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int t;
        int d;
        reset = 1'b0;
        req   = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        // Requests held during reset must not latch.
        check("rst_pending", int'(pending), 0);
        check("rst_floor", int'(cur_floor), 0);
        check("rst_onehot", int'(floor_onehot), 1);
        check("rst_dir", int'(direction), 0);
        check("rst_door", int'(door_open), 0);
        check("rst_above", int'(above), 0);
        check("rst_below", int'(below), 0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        req = 4'b0000;
        check("rel_pending", int'(pending), 4'b1000);
        check("rel_dir", int'(direction), 2'b10);
        check("rel_above", int'(above), 1);
        repeat (9) @(posedge clk);
        #1;
        check("mv_floor", int'(cur_floor), 1);
        check("mv_onehot", int'(floor_onehot), 4'b0010);
        check("mv_below", int'(below), 0);
        // Asynchronous reset while moving up.
        reset = 1'b0;
        #1;
        check("mid_rst_floor", int'(cur_floor), 0);
        check("mid_rst_dir", int'(direction), 0);
        check("mid_rst_pending", int'(pending), 0);
        check("mid_rst_onehot", int'(floor_onehot), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Same-floor request while idle.
        pulse(4'b0001, t);
        push_stop(0, t + 1, 4);
        check("same_door", int'(door_open), 1);
        check("same_dir", int'(direction), 0);
        check("same_pending", int'(pending), 0);
        wait_idle(40);

        // Floor 0 -> floor 2.
        pulse(4'b0100, t);
        push_stop(2, t + 17, 4);
        check("up2_dir", int'(direction), 2'b10);
        check("up2_above", int'(above), 1);
        goto(t + 9);
        check("up2_floor1", int'(cur_floor), 1);
        goto(t + 17);
        check("up2_floor2", int'(cur_floor), 2);
        check("up2_above_clr", int'(above), 0);
        wait_idle(80);
        check("up2_idle_door", int'(door_open), 0);

        // SCAN: floor 0 request arrives mid-trip to floor 3.
        do_reset();
        @(posedge clk);
        #1;
        pulse(4'b1000, t);
        push_stop(3, t + 25, 4);
        push_stop(0, t + 53, 4);
        goto(t + 12);
        pulse(4'b0001, d);
        check("scan_pending", int'(pending), 4'b1001);
        goto(t + 30);
        check("scan_dir_down", int'(direction), 2'b01);
        check("scan_below", int'(below), 1);
        wait_idle(120);

        // Pass-by, request in time: stop at 2 then 3.
        pulse(4'b1000, t);
        push_stop(2, t + 17, 4);
        push_stop(3, t + 29, 4);
        goto(t + 14);
        pulse(4'b0100, d);
        wait_idle(120);

        // Return to floor 0.
        pulse(4'b0001, t);
        push_stop(0, t + 25, 4);
        wait_idle(120);

        // Pass-by, request just after the floor-2 arrival edge.
        pulse(4'b1000, t);
        push_stop(3, t + 25, 4);
        push_stop(2, t + 37, 4);
        goto(t + 17);
        pulse(4'b0100, d);
        check("late_pending", int'(pending), 4'b1100);
        check("late_floor", int'(cur_floor), 2);
        wait_idle(120);

        // Door re-press extends the dwell.
        pulse(4'b0100, t);
        push_stop(2, t + 1, 7);
        goto(t + 3);
        pulse(4'b0100, d);
        check("extend_pending", int'(pending), 0);
        check("extend_door", int'(door_open), 1);
        wait_idle(40);
        check("final_floor", int'(cur_floor), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
